// File: rtl/axi_rd_pkg.sv
// Shared types and AXI4 constants for the single-burst read master.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } rd_state_e;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY   = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR   = 2'b11;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

    // AxSIZE encodes bytes per beat as a power of two.
    function automatic logic [2:0] axi_arsize(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_rd_burst_master.sv
// Turns one start/address/length request into a single AXI4 INCR read burst
// and hands the returned beats, a done pulse and an error flag back upstream.
module axi_rd_burst_master
    import axi_rd_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH     = 1,
    parameter int C_M_AXI_ADDR_WIDTH   = 32,
    parameter int C_M_AXI_DATA_WIDTH   = 32,
    parameter int C_M_AXI_ARUSER_WIDTH = 0,
    parameter int C_M_AXI_RUSER_WIDTH  = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   rd_addr,
    input  logic [7:0]                      rd_len,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                            rd_vld,
    output logic                            rd_done,
    output logic                            rd_busy,
    output logic                            rd_err,
    output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                      m_axi_arlen,
    output logic [2:0]                      m_axi_arsize,
    output logic [1:0]                      m_axi_arburst,
    output logic                            m_axi_arlock,
    output logic [3:0]                      m_axi_arcache,
    output logic [2:0]                      m_axi_arprot,
    output logic [3:0]                      m_axi_arqos,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rlast,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    localparam logic [2:0] AR_SIZE = axi_arsize(C_M_AXI_DATA_WIDTH);
    localparam int unused_user_w = C_M_AXI_ARUSER_WIDTH + C_M_AXI_RUSER_WIDTH;

    rd_state_e                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]      araddr_q, araddr_d;
    logic [7:0]                         arlen_q, arlen_d;
    logic [7:0]                         beat_cnt_q, beat_cnt_d;
    logic                               arvalid_q, arvalid_d;
    logic                               rready_q, rready_d;
    logic                               rd_vld_q, rd_vld_d;
    logic                               rd_done_q, rd_done_d;
    logic                               rd_err_q, rd_err_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]      rd_data_q, rd_data_d;

    logic ar_hs;
    logic r_beat;
    logic beat_in_range;
    logic beat_is_final;
    logic unused_r_fields;

    assign unused_r_fields = ^{m_axi_rid, m_axi_rresp[0]};

    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        beat_cnt_d = beat_cnt_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        rd_err_d   = rd_err_q;
        rd_data_d  = rd_data_q;
        rd_vld_d   = 1'b0;
        rd_done_d  = 1'b0;

        ar_hs         = arvalid_q & m_axi_arready;
        r_beat        = rready_q & m_axi_rvalid;
        beat_in_range = (beat_cnt_q <= arlen_q);
        beat_is_final = (beat_cnt_q == arlen_q);

        case (state_q)
            ST_IDLE: begin
                if (rd_start) begin
                    araddr_d   = rd_addr;
                    arlen_d    = (rd_len == 8'd0) ? 8'd0 : rd_len - 8'd1;
                    beat_cnt_d = 8'd0;
                    rd_err_d   = 1'b0;
                    arvalid_d  = 1'b1;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_beat) begin
                    // Beats beyond the requested count are drained but not forwarded.
                    if (beat_in_range) begin
                        rd_vld_d  = 1'b1;
                        rd_data_d = m_axi_rdata;
                    end
                    if (beat_cnt_q != 8'hFF) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                    if (m_axi_rresp[1]) begin
                        rd_err_d = 1'b1;
                    end
                    if (m_axi_rlast != beat_is_final) begin
                        rd_err_d = 1'b1;
                    end
                    if (m_axi_rlast) begin
                        rready_d  = 1'b0;
                        rd_done_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            araddr_q   <= '0;
            arlen_q    <= '0;
            beat_cnt_q <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            beat_cnt_q <= beat_cnt_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            rd_vld_q   <= rd_vld_d;
            rd_done_q  <= rd_done_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_vld  = rd_vld_q;
    assign rd_done = rd_done_q;
    assign rd_busy = (state_q != ST_IDLE);
    assign rd_err  = rd_err_q;

    // Fixed AR attributes are only presented alongside arvalid so reset shows all zeros.
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = arvalid_q ? AR_SIZE : 3'd0;
    assign m_axi_arburst = arvalid_q ? AXI_BURST_INCR : 2'd0;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = arvalid_q ? AXI_CACHE_DEFAULT : 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Directed bench for axi_rd_burst_master with a scripted AXI read slave.
module tb_axi_rd_burst_master;

    logic        clk;
    logic        rst;
    logic        rd_start;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic [31:0] rd_data;
    logic        rd_vld;
    logic        rd_done;
    logic        rd_busy;
    logic        rd_err;
    logic [0:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [0:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int checks = 0;
    int errors = 0;

    // Slave script and observations
    int          slv_beats    = 1;
    int          slv_last_at  = 1;
    int          slv_err_beat = 0;
    int          slv_gaps     = 0;
    int          delay_left   = 0;
    logic [31:0] slv_base     = '0;
    int          ar_count     = 0;
    logic [31:0] ar_addr_seen = '0;
    logic [7:0]  ar_len_seen  = '0;
    int          beat_idx     = 0;
    int          burst_active = 0;
    int          r_hs_pend    = 0;

    // Monitor observations
    logic [31:0] beats_q[$];
    int          done_cnt    = 0;
    logic        err_at_done = 1'b0;
    logic        vld_at_done = 1'b0;

    axi_rd_burst_master dut (
        .clk           (clk),
        .rst           (rst),
        .rd_start      (rd_start),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_data       (rd_data),
        .rd_vld        (rd_vld),
        .rd_done       (rd_done),
        .rd_busy       (rd_busy),
        .rd_err        (rd_err),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arqos   (m_axi_arqos),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {m_axi_arvalid, m_axi_rready, rd_vld, rd_done, rd_busy, rd_err}, 0);
        check({tag, "_data"}, rd_data, 0);
        check({tag, "_araddr"}, m_axi_araddr, 0);
        check({tag, "_arlen"}, m_axi_arlen, 0);
        check({tag, "_attr"}, {m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arid}, 0);
    endtask

    task automatic slave_cfg(input int beats, input int last_at, input int err_beat,
                             input int gaps, input int ar_delay, input logic [31:0] base);
        slv_beats    = beats;
        slv_last_at  = last_at;
        slv_err_beat = err_beat;
        slv_gaps     = gaps;
        delay_left   = ar_delay;
        slv_base     = base;
        beats_q.delete();
        done_cnt     = 0;
        ar_count     = 0;
    endtask

    task automatic start_txn(input logic [31:0] addr, input logic [7:0] len);
        rd_start = 1'b1;
        rd_addr  = addr;
        rd_len   = len;
        step();
        rd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int max_cycles);
        for (int n = 0; n < max_cycles && done_cnt < target; n++) step();
        check({tag, "_done_seen"}, done_cnt, target);
    endtask

    // Scripted AXI slave: decides at each falling edge what the next rising edge sees
    initial begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rid     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                burst_active  = 0;
                r_hs_pend     = 0;
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
            end else begin
                if (r_hs_pend != 0) begin
                    beat_idx++;
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                end
                m_axi_arready = 1'b0;
                if (m_axi_arvalid && burst_active == 0) begin
                    if (delay_left > 0) begin
                        delay_left--;
                    end else begin
                        m_axi_arready = 1'b1;
                        ar_count++;
                        ar_addr_seen  = m_axi_araddr;
                        ar_len_seen   = m_axi_arlen;
                        burst_active  = 1;
                        beat_idx      = 0;
                    end
                end
                if (burst_active != 0) begin
                    if (beat_idx >= slv_beats) begin
                        burst_active = 0;
                        m_axi_rvalid = 1'b0;
                        m_axi_rlast  = 1'b0;
                    end else if (!m_axi_rvalid) begin
                        if (slv_gaps == 0 || $urandom_range(0, 2) != 0) begin
                            m_axi_rvalid = 1'b1;
                            m_axi_rdata  = slv_base + 32'(beat_idx);
                            m_axi_rlast  = (beat_idx + 1 == slv_last_at);
                            m_axi_rresp  = (beat_idx + 1 == slv_err_beat) ? 2'b10 : 2'b00;
                        end
                    end
                end
                r_hs_pend = (m_axi_rvalid && m_axi_rready) ? 1 : 0;
            end
        end
    end

    // Upstream monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rd_vld) beats_q.push_back(rd_data);
            if (rd_done) begin
                done_cnt++;
                err_at_done = rd_err;
                vld_at_done = rd_vld;
            end
        end
    end

    initial begin
        rst      = 1'b1;
        rd_start = 1'b0;
        rd_addr  = '0;
        rd_len   = '0;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 7; i++) step();

        // Single beat, no wait states
        slave_cfg(1, 1, 0, 0, 0, 32'hDEADBEEF);
        start_txn(32'h0000_1000, 8'd1);
        check("t1_busy_n1", rd_busy, 1);
        check("t1_arvalid_n1", m_axi_arvalid, 1);
        check("t1_araddr", m_axi_araddr, 32'h1000);
        check("t1_arlen", m_axi_arlen, 0);
        check("t1_arsize", m_axi_arsize, 3'd2);
        check("t1_arburst_cache", {m_axi_arburst, m_axi_arcache}, {2'b01, 4'b0011});
        check("t1_rready_n1", m_axi_rready, 0);
        step();
        check("t1_rready_n2", {m_axi_rready, m_axi_arvalid, rd_vld, rd_busy}, 4'b1001);
        step();
        check("t1_n3_flags", {rd_vld, rd_done, rd_busy, rd_err}, 4'b1110);
        check("t1_rd_data", rd_data, 32'hDEADBEEF);
        step();
        check("t1_n4_flags", {rd_vld, rd_done, rd_busy}, 3'b000);
        check("t1_ar_count", ar_count, 1);

        // 16 beats, delayed arready, random rvalid gaps
        slave_cfg(16, 16, 0, 1, 5, 32'h1000_0000);
        start_txn(32'h0002_0000, 8'd16);
        wait_done("t2", 1, 400);
        check("t2_arlen", ar_len_seen, 8'd15);
        check("t2_araddr", ar_addr_seen, 32'h0002_0000);
        check("t2_vld_count", beats_q.size(), 16);
        for (int i = 0; i < 16 && i < beats_q.size(); i++)
            check($sformatf("t2_beat%0d", i), beats_q[i], 32'h1000_0000 + 32'(i));
        check("t2_vld_with_done", vld_at_done, 1);
        check("t2_err", err_at_done, 0);
        step();
        check("t2_busy_after", rd_busy, 0);
        check("t2_single_done", done_cnt, 1);

        // SLVERR on beat 3 of 4
        slave_cfg(4, 4, 3, 0, 0, 32'h2000_0000);
        start_txn(32'h0000_4000, 8'd4);
        wait_done("t3", 1, 100);
        check("t3_vld_count", beats_q.size(), 4);
        check("t3_err", err_at_done, 1);
        step();
        check("t3_err_held", rd_err, 1);
        slave_cfg(2, 2, 0, 0, 0, 32'h2100_0000);
        start_txn(32'h0000_5000, 8'd2);
        check("t3_err_cleared_on_accept", rd_err, 0);
        wait_done("t3b", 1, 100);
        check("t3b_err", err_at_done, 0);
        step();

        // Early rlast on beat 2 of 4
        slave_cfg(2, 2, 0, 0, 0, 32'h3000_0000);
        start_txn(32'h0000_6000, 8'd4);
        wait_done("t4a", 1, 100);
        check("t4a_err", err_at_done, 1);
        check("t4a_vld_count", beats_q.size(), 2);
        step();

        // rlast only on beat 6 of a 4-beat request
        slave_cfg(6, 6, 0, 0, 0, 32'h4000_0000);
        start_txn(32'h0000_7000, 8'd4);
        wait_done("t4b", 1, 100);
        check("t4b_err", err_at_done, 1);
        check("t4b_vld_count", beats_q.size(), 4);
        check("t4b_slave_beats", beat_idx, 6);
        if (beats_q.size() == 4) check("t4b_last_fwd", beats_q[3], 32'h4000_0003);
        step();

        // rd_start held high, rd_len = 0
        slave_cfg(1, 1, 0, 0, 0, 32'h5000_0000);
        rd_start = 1'b1;
        rd_addr  = 32'h0000_8000;
        rd_len   = 8'd0;
        wait_done("t5_first", 1, 50);
        check("t5_ar_after_first", ar_count, 1);
        check("t5_arlen", ar_len_seen, 0);
        wait_done("t5_second", 2, 50);
        rd_start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("t5_ar_total", ar_count, 2);
        check("t5_done_total", done_cnt, 2);

        // Reset in the middle of a burst
        slave_cfg(8, 8, 0, 0, 0, 32'h6000_0000);
        start_txn(32'h0000_9000, 8'd8);
        for (int n = 0; n < 50 && beats_q.size() < 2; n++) step();
        check("t6_midburst", {rd_busy, m_axi_rready}, 2'b11);
        rst = 1'b1;
        #1;
        check_zero("t6_rst");
        step();
        step();
        rst = 1'b0;
        step();
        slave_cfg(1, 1, 0, 0, 0, 32'hCAFE0000);
        start_txn(32'h0000_A000, 8'd1);
        check("t6_accept_after_rst", {rd_busy, m_axi_arvalid}, 2'b11);
        wait_done("t6_post", 1, 50);
        check("t6_post_data", rd_data, 32'hCAFE0000);
        check("t6_post_err", err_at_done, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_burst_master.md
# axi_rd_burst_master

Converts a single-beat-request user read command (start/address/length) into one AXI4 INCR read burst, and returns the read beats, a done pulse and a busy flag to the read-side FIFO controller. It sits directly downstream of the DDR read FIFO controller, which drives `rd_start`/`rd_addr`/`rd_len`. It also sits directly upstream of the AXI interconnect / DDR3 MIG slave port. One transaction is outstanding at a time.

## Interface
Parameters:
- C_M_AXI_ID_WIDTH, 1, ARID/RID width
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width; power of two, 8..1024
- C_M_AXI_ARUSER_WIDTH / C_M_AXI_RUSER_WIDTH, 0, user widths; unused, no user ports

Ports:
- clk  in  1  system (DDR user) clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- rd_start  in  1  request; sampled only in IDLE
- rd_addr  in  ADDR_W  burst start byte address; sampled on accept
- rd_len  in  8  beats in burst (1..255); 0 treated as 1
- rd_data  out  DATA_W  returned beat data
- rd_vld  out  1  rd_data valid, one cycle per beat
- rd_done  out  1  one-cycle pulse, transaction complete
- rd_busy  out  1  high from the cycle after accept through the rd_done cycle
- rd_err  out  1  error flag for the last transaction; valid with rd_done, held until next accept
- m_axi_arid/araddr/arlen[7:0]/arsize[2:0]/arburst[1:0]/arlock/arcache[3:0]/arprot[2:0]/arqos[3:0]/arvalid  out  AR channel
- m_axi_arready  in  1
- m_axi_rid/rdata/rresp[1:0]/rlast/rvalid  in  R channel
- m_axi_rready  out  1

## Operation
- States are IDLE, ADDR, DATA, DONE. `rd_busy` is 1 in every state except IDLE.
- **IDLE:** when `rd_start` is 1, latch the address and `arlen = max(rd_len,1) - 1`, clear `rd_err` and the beat counter, then go to ADDR. `rd_start` is ignored in all other states.
- **ADDR:** `arvalid` is 1. `araddr` and `arlen` are held stable. On `arvalid & arready`, go to DATA.
- **DATA:** `rready` is 1. Each `rvalid & rready` is one beat:
  - register `rdata` to `rd_data` and pulse `rd_vld`;
  - increment the beat counter;
  - if `rresp[1]` is 1 (SLVERR/DECERR), set `rd_err`.
- **Leaving DATA:** go to DONE on the beat with `rlast`.
  - If `rlast` arrives before beat `arlen+1`, set `rd_err`.
  - If beat `arlen+1` arrives without `rlast`, set `rd_err`; keep accepting beats until `rlast` arrives, and do not forward beats past the count to `rd_vld`.
- **DONE:** `rd_done` is 1 for one cycle, then go to IDLE.
- **Constant AR fields:**
  - arsize = log2(DATA_W/8)
  - arburst = INCR (2'b01)
  - arcache = 4'b0011
  - arlock, arprot, arqos, arid = 0
- **Caller's responsibility:** 4 KB boundary and alignment are not checked. `m_axi_rid` is ignored.

## Timing
- **Reset:** while `rst` is 1 (asynchronous assert), state = IDLE and every output is 0, including `arvalid`, `rready`, `rd_vld`, `rd_done`, `rd_busy`, `rd_err`, `rd_data` and `araddr`. Reset mid-burst abandons the burst; the slave is reset by the same `rst`.
- **Accept:** `rd_start` is accepted at cycle N. `rd_busy` and `arvalid` go to 1 at N+1.
- **Address handshake:** the handshake occurs at cycle A (earliest A = N+1). `rready` goes to 1 at A+1.
- **Data beats:** a beat handshake at cycle B gives `rd_vld`/`rd_data` at B+1.
- **Last beat:** the last beat is at cycle L. At L+1, the last `rd_vld`, `rd_done`, `rd_busy` = 1 and the final `rd_err` all appear together. At L+2, `rd_busy` = 0.
- **Back-to-back:** the earliest next accept is L+2. `rd_busy` is still 1 in the `rd_done` cycle, so an upstream `rd_addr` update on `rd_done` is safe.
- **Minimum transaction:** 1 beat, no wait states: start at N, `rd_done` at N+3, next accept at N+4.
- **Stalls:** an `arready` stall holds ADDR indefinitely. `rvalid` gaps are tolerated without limit.

## Structure
- Shared package `axi_rd_pkg`:
  - state enum;
  - constants AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, AXI_CACHE_DEFAULT;
  - function clog2-based arsize from data width.
- Single module with no sub-module. The beat counter (8 bit) and state register are local.

## Test plan
- **Single beat:** `rd_start` at cycle 10, `rd_addr` = 0x0000_1000, `rd_len` = 1, `arready` tied 1, R returns 0xDEADBEEF with `rlast` at cycle 12.
  - Required: `araddr` = 0x1000, `arlen` = 0, `arsize` = 2.
  - Required: `rd_vld` and `rd_done` at 13, `rd_busy` 11..13.
- **16-beat burst with random gaps:** `rd_len` = 16, `arready` delayed 5 cycles, random `rvalid` gaps.
  - Required: `arlen` = 15 and exactly 16 `rd_vld` carrying beats in order.
  - Required: one `rd_done` together with the 16th beat, `rd_err` = 0.
- **Error response:** `rresp` = SLVERR on beat 3 of 4.
  - Required: all 4 beats forwarded and `rd_err` = 1 at `rd_done`.
  - Required: a following clean request clears `rd_err` at accept.
- **`rlast` mismatch:** (a) `rlast` on beat 2 of `rd_len` = 4; (b) no `rlast` until beat 6.
  - Required: `rd_err` = 1 in both cases.
  - Required (b): only 4 `rd_vld` pulses, and `rd_done` follows beat 6.
- **Request gating and reset:**
  - `rd_start` held high continuously: exactly one AR per transaction, with `rd_len` = 0 giving `arlen` = 0.
  - `rst` pulsed mid-DATA: all outputs go to 0 immediately and the next `rd_start` is accepted normally.
